// File: rtl/cordic_seq_if.sv
// ============================================================================
// Module   : cordic_seq_if
// Brief    : Angle/result handshakes and atan ROM port of the CORDIC sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface cordic_seq_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] angle_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] cos_out;
  logic [DATA_WIDTH-1:0] sin_out;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_q;

  // Sequencer side
  modport slave (
    input  in_valid, angle_in, out_ready, rom_q,
    output in_ready, out_valid, cos_out, sin_out, rom_addr
  );

  // Angle source, result consumer and ROM side
  modport master (
    output in_valid, angle_in, out_ready, rom_q,
    input  in_ready, out_valid, cos_out, sin_out, rom_addr
  );
endinterface

`default_nettype wire

// File: rtl/cordic_seq.sv
// ============================================================================
// Module   : cordic_seq
// Brief    : Iterative rotation-mode CORDIC, one micro-rotation per clock,
//            producing cos/sin of a signed angle. Optional quadrant
//            pre-rotation is enabled by defining CORDIC_QUAD_EXT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cordic_seq #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    ITER       = 16,
  parameter logic [DATA_WIDTH-1:0] K_INIT     = 16'h26DD
) (
  input  wire         clk,
  input  wire         rst,
  cordic_seq_if.slave bus
);

  localparam int                    c_XW   = DATA_WIDTH + 2;
  localparam int                    c_ZW   = DATA_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] c_LAST = ADDR_WIDTH'(ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                  r_state;
  logic signed [c_XW-1:0]  r_x;
  logic signed [c_XW-1:0]  r_y;
  logic signed [c_ZW-1:0]  r_z;
  logic [ADDR_WIDTH-1:0]   r_i;
  logic                    r_out_valid;

  logic signed [c_XW-1:0]  w_x_sh;
  logic signed [c_XW-1:0]  w_y_sh;
  logic signed [c_ZW-1:0]  w_rom_ext;
  logic signed [c_ZW-1:0]  w_angle_ext;
  logic signed [c_XW-1:0]  w_k_ext;
  logic signed [c_XW-1:0]  w_x0;
  logic signed [c_XW-1:0]  w_y0;
  logic signed [c_ZW-1:0]  w_z0;
  logic                    w_accept;

  assign w_x_sh      = r_x >>> r_i;
  assign w_y_sh      = r_y >>> r_i;
  assign w_rom_ext   = $signed({bus.rom_q[DATA_WIDTH-1], bus.rom_q});
  assign w_angle_ext = $signed({bus.angle_in[DATA_WIDTH-1], bus.angle_in});
  assign w_k_ext     = $signed({{2{K_INIT[DATA_WIDTH-1]}}, K_INIT});
  assign w_accept    = bus.in_valid && (r_state == S_IDLE);

`ifdef CORDIC_QUAD_EXT_EN
  localparam logic signed [c_ZW-1:0] c_HALF_PI = c_ZW'(25736);

  // Angles beyond +/-pi/2 start from the (0, +/-K) vector with the residue.
  always_comb begin
    w_x0 = w_k_ext;
    w_y0 = '0;
    w_z0 = w_angle_ext;
    if (w_angle_ext > c_HALF_PI) begin
      w_x0 = '0;
      w_y0 = w_k_ext;
      w_z0 = w_angle_ext - c_HALF_PI;
    end else if (w_angle_ext < -c_HALF_PI) begin
      w_x0 = '0;
      w_y0 = -w_k_ext;
      w_z0 = w_angle_ext + c_HALF_PI;
    end
  end
`else
  always_comb begin
    w_x0 = w_k_ext;
    w_y0 = '0;
    w_z0 = w_angle_ext;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_z         <= '0;
      r_i         <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_x     <= w_x0;
            r_y     <= w_y0;
            r_z     <= w_z0;
            r_i     <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          // Negative residual angle rotates clockwise (d = -1).
          if (r_z[c_ZW-1]) begin
            r_x <= r_x + w_y_sh;
            r_y <= r_y - w_x_sh;
            r_z <= r_z + w_rom_ext;
          end else begin
            r_x <= r_x - w_y_sh;
            r_y <= r_y + w_x_sh;
            r_z <= r_z - w_rom_ext;
          end
          if (r_i == c_LAST) begin
            r_i         <= '0;
            r_state     <= S_HOLD;
            r_out_valid <= 1'b1;
          end else begin
            r_i <= r_i + ADDR_WIDTH'(1);
          end
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE) && !rst;
  assign bus.out_valid = r_out_valid;
  assign bus.cos_out   = r_x[DATA_WIDTH-1:0];
  assign bus.sin_out   = r_y[DATA_WIDTH-1:0];
  assign bus.rom_addr  = r_i;

endmodule

`default_nettype wire

// File: tb/tb_cordic_seq.sv
// ============================================================================
// Module   : tb_cordic_seq
// Brief    : Directed self-checking bench for cordic_seq with an atan ROM model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cordic_seq;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   cyc;

  cordic_seq_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) bus ();

  cordic_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] rom [16];
  initial begin
    rom[0]  = 16'd12868; rom[1]  = 16'd7596; rom[2]  = 16'd4014; rom[3]  = 16'd2037;
    rom[4]  = 16'd1023;  rom[5]  = 16'd512;  rom[6]  = 16'd256;  rom[7]  = 16'd128;
    rom[8]  = 16'd64;    rom[9]  = 16'd32;   rom[10] = 16'd16;   rom[11] = 16'd8;
    rom[12] = 16'd4;     rom[13] = 16'd2;    rom[14] = 16'd1;    rom[15] = 16'd0;
  end
  assign bus.rom_q = rom[bus.rom_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int absdiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Accept one angle and wait (bounded) for out_valid; reports latency and
  // the number of RUN cycles where rom_addr or in_ready were wrong.
  task automatic run_op(input logic [15:0] ang, output int lat, output int addr_err,
                        output int rdy_err, output int cos_v, output int sin_v);
    addr_err = 0;
    rdy_err  = 0;
    @(negedge clk);
    if (bus.in_ready !== 1'b1) rdy_err++;
    bus.in_valid = 1'b1;
    bus.angle_in = ang;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      if (bus.rom_addr !== 4'(lat)) addr_err++;
      if (bus.in_ready !== 1'b0) rdy_err++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    cos_v = int'($signed(bus.cos_out));
    sin_v = int'($signed(bus.sin_out));
  endtask

  task automatic release_result();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.angle_in = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.cos_out !== 16'd0 || bus.sin_out !== 16'd0 ||
        bus.rom_addr !== 4'd0 || bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: ov=%b cos=%0d sin=%0d addr=%0d rdy=%b, required 0/0/0/0/0",
               bus.out_valid, bus.cos_out, bus.sin_out, bus.rom_addr, bus.in_ready);
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: in_ready=%b required 1", bus.in_ready);
    end
  endtask

  task automatic test_angles();
    logic [15:0] angs [3];
    int exp_c [3];
    int exp_s [3];
    int lat, ae, re, c, s;
    angs[0] = 16'd0;     exp_c[0] = 16384; exp_s[0] = 0;
    angs[1] = 16'd12868; exp_c[1] = 11585; exp_s[1] = 11585;
    angs[2] = 16'hDE7D;  exp_c[2] = 14189; exp_s[2] = -8192;   // -8579
    for (int k = 0; k < 3; k++) begin
      run_op(angs[k], lat, ae, re, c, s);
      checks++;
      if (lat !== 16) begin
        failures++;
        $display("FAIL latency[%0d]: got %0d edges, required 16", k, lat);
      end
      checks++;
      if (ae !== 0 || re !== 0) begin
        failures++;
        $display("FAIL run_seq[%0d]: rom_addr errors=%0d in_ready errors=%0d, required 0/0", k, ae, re);
      end
      checks++;
      if (absdiff(c, exp_c[k]) > 4 || absdiff(s, exp_s[k]) > 4) begin
        failures++;
        $display("FAIL result[%0d]: cos=%0d sin=%0d, required %0d/%0d +-4", k, c, s, exp_c[k], exp_s[k]);
      end
      release_result();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL release[%0d]: ov=%b rdy=%b, required 0/1", k, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat, ae, re, c, s, bad;
    logic [15:0] hc, hs;
    run_op(16'd12868, lat, ae, re, c, s);
    hc = bus.cos_out;
    hs = bus.sin_out;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      bus.in_valid = k[0];
      bus.angle_in = 16'd4000;
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.cos_out !== hc || bus.sin_out !== hs) bad++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL backpressure_hold: %0d unstable cycles, required 0", bad);
    end
    release_result();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL backpressure_release: ov=%b rdy=%b, required 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_midrun();
    int seen, lat, ae, re, c, s;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.angle_in = 16'd12868;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.rom_addr !== 4'd0 || bus.cos_out !== 16'd0) begin
      failures++;
      $display("FAIL midrun_reset: ov=%b addr=%0d cos=%0d, required 0/0/0",
               bus.out_valid, bus.rom_addr, bus.cos_out);
    end
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrun_no_result: out_valid cycles=%0d rdy=%b, required 0/1", seen, bus.in_ready);
    end
    run_op(16'd0, lat, ae, re, c, s);
    checks++;
    if (lat !== 16 || absdiff(c, 16384) > 4 || absdiff(s, 0) > 4) begin
      failures++;
      $display("FAIL midrun_recover: lat=%0d cos=%0d sin=%0d, required 16/16384/0", lat, c, s);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    int rises [$];
    int bad_val, bad_rdy, bad_addr, exp_addr;
    logic prev_ov;
    bad_val = 0; bad_rdy = 0; bad_addr = 0;
    exp_addr = 0;
    prev_ov = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    bus.angle_in = 16'hDE7D;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid && !prev_ov) begin
        rises.push_back(cyc);
        if (absdiff(int'($signed(bus.cos_out)), 14189) > 4 ||
            absdiff(int'($signed(bus.sin_out)), -8192) > 4) bad_val++;
      end
      if (bus.out_valid && bus.in_ready) bad_rdy++;
      // RUN cycles: neither ready nor valid
      if (!bus.out_valid && !bus.in_ready) begin
        if (bus.rom_addr !== 4'(exp_addr)) bad_addr++;
        exp_addr = (exp_addr + 1) % 16;
      end
      prev_ov = bus.out_valid;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (rises.size() < 3) begin
      failures++;
      $display("FAIL b2b_count: %0d results, required >= 3", rises.size());
    end else begin
      checks++;
      if (rises[1] - rises[0] !== 18 || rises[2] - rises[1] !== 18) begin
        failures++;
        $display("FAIL b2b_period: %0d,%0d cycles, required 18,18",
                 rises[1] - rises[0], rises[2] - rises[1]);
      end
    end
    checks++;
    if (bad_val !== 0 || bad_rdy !== 0 || bad_addr !== 0) begin
      failures++;
      $display("FAIL b2b_stream: value errs=%0d ready errs=%0d addr errs=%0d, required 0",
               bad_val, bad_rdy, bad_addr);
    end
    repeat (20) @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

`ifdef CORDIC_QUAD_EXT_EN
  task automatic test_quad_ext();
    int lat, ae, re, c, s;
    run_op(16'd30000, lat, ae, re, c, s);
    checks++;
    if (lat !== 16 || absdiff(c, -4217) > 6 || absdiff(s, 15832) > 6) begin
      failures++;
      $display("FAIL quad_pos: lat=%0d cos=%0d sin=%0d, required 16/-4217/15832", lat, c, s);
    end
    release_result();
    run_op(16'h8AD0, lat, ae, re, c, s);   // -30000
    checks++;
    if (lat !== 16 || absdiff(c, -4217) > 6 || absdiff(s, -15832) > 6) begin
      failures++;
      $display("FAIL quad_neg: lat=%0d cos=%0d sin=%0d, required 16/-4217/-15832", lat, c, s);
    end
    release_result();
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    test_reset();
    test_angles();
    test_backpressure();
    test_reset_midrun();
    test_back_to_back();
`ifdef CORDIC_QUAD_EXT_EN
    test_quad_ext();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/cordic_seq.md
# cordic_seq

Iterative CORDIC rotation-mode sequencer producing 16-bit cosine/sine of an input angle. It owns the iteration counter, drives the address of the external asynchronous arctangent ROM, and performs one shift-add micro-rotation per clock. It sits between the angle source (valid/ready producer) and the consumer of sin/cos results (valid/ready consumer).

## Interface
- DATA_WIDTH, 16: angle and result width. Signed two's complement; 1.0 = 2^14 = 16384.
- ADDR_WIDTH, 4: ROM address width.
- ITER, 16: micro-rotations per operation. Must satisfy ITER ≤ 2**ADDR_WIDTH.
- K_INIT, 16'h26DD: CORDIC gain compensation for 16 iterations (0.60725·16384 = 9949).
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  angle_in valid.
- in_ready  out  1  block idle, can accept an angle.
- angle_in  in  DATA_WIDTH  angle in radians·2^14, signed.
- out_valid  out  1  cos_out/sin_out valid.
- out_ready  in  1  consumer accepts the result.
- cos_out  out  DATA_WIDTH  cos(angle)·2^14.
- sin_out  out  DATA_WIDTH  sin(angle)·2^14.
- rom_addr  out  ADDR_WIDTH  iteration index to the atan ROM.
- rom_q  in  DATA_WIDTH  atan(2^-rom_addr)·2^14, combinational from rom_addr.

## Operation
- States: IDLE, RUN, HOLD. Reset → IDLE.
- in_ready = (state == IDLE) && !rst. Accept on an edge where in_valid && in_ready.
- Accept: x ← K_INIT, y ← 0, z ← angle_in (sign-extended), i ← 0, state ← RUN.
- RUN, each edge: d = +1 if z ≥ 0, else −1. x ← x − d·(y >>> i); y ← y + d·(x >>> i); z ← z − d·rom_q; i ← i+1. Shifts are arithmetic.
- After the update with i == ITER−1: state ← HOLD, out_valid ← 1, i ← 0.
- HOLD: cos_out = x[DATA_WIDTH−1:0], sin_out = y[DATA_WIDTH−1:0], held stable. On an edge with out_ready high: state ← IDLE, out_valid ← 0.
- In_valid during RUN/HOLD is ignored; no queuing. Accept cannot occur in the same cycle as the HOLD→IDLE exit (one-cycle bubble).
- Internal widths: x, y DATA_WIDTH+2; z DATA_WIDTH+1. Outputs are truncated, not saturated; guaranteed in range for valid inputs.
- Valid input range without extension: |angle_in| ≤ 25736 (π/2). Results outside this range are unspecified; no hang, and the FSM still completes.
- rst in any state: next edge returns to IDLE and clears all registers. In-flight operation is discarded, with no out_valid pulse.

## Timing
- Reset values: out_valid 0, cos_out 0, sin_out 0, rom_addr 0, in_ready 0 while rst high and 1 the cycle after.
- rom_addr = i (registered). rom_q is consumed in the same cycle.
- Latency: out_valid rises exactly ITER edges after the accept edge (16 by default).
- Throughput: one result per ITER+2 cycles when out_ready is held high.
- out_valid, once high, stays high with stable data until the out_ready handshake.

## Configuration
- CORDIC_QUAD_EXT_EN defined: quadrant pre-rotation at accept, valid for the full signed range (±2.0 rad).
  - angle_in > 25736: x ← 0, y ← K_INIT, z ← angle_in − 25736.
  - angle_in < −25736: x ← 0, y ← −K_INIT, z ← angle_in + 25736.
  - Otherwise: as above.
  - Latency is unchanged.
- CORDIC_QUAD_EXT_EN undefined: no pre-rotation logic. Range is limited to ±25736.

## Test plan
- Reset, then angle_in 0 → out_valid after 16 edges; cos_out 16384 ±4, sin_out 0 ±4.
- angle_in 12868 (π/4) → cos_out and sin_out each 11585 ±4. angle_in −8579 (−30°) → cos_out 14189 ±4, sin_out −8192 ±4.
- Backpressure: out_ready low for 10 cycles after out_valid → outputs stable, in_ready 0, in_valid pulses ignored. out_ready high → IDLE next edge, in_ready 1.
- Reset asserted at RUN cycle 5 → next edge: state IDLE, out_valid 0, rom_addr 0, no result emitted. A new angle is then accepted normally.
- Back-to-back: in_valid and out_ready held high → rom_addr sequences 0..15, results every 18 cycles, in_ready low during RUN/HOLD.
- CORDIC_QUAD_EXT_EN defined: angle_in 30000 → cos_out −4217 ±6, sin_out 15832 ±6. angle_in −30000 → cos_out −4217 ±6, sin_out −15832 ±6.
